// File: rtl/spi_peripheral.sv
// SPI mode-0 peripheral: oversamples the controller's SCLK/CS_n/COPI in the
// i_clk domain, shifts bytes MSB-first, and exchanges them through a one-deep TX holding register.
module spi_peripheral #(
    parameter logic [7:0] IDLE_BYTE = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [7:0] i_tx_byte,
    input  logic       i_tx_dv,
    output logic       o_tx_ready,
    output logic       o_rx_dv,
    output logic [7:0] o_rx_byte,
    input  logic       i_spi_clk,
    input  logic       i_spi_cs_n,
    input  logic       i_spi_copi,
    output logic       o_spi_cipo,
    output logic       o_spi_cipo_en
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t state, state_next;

    logic sclk_meta, sclk_sync, sclk_prev;
    logic cs_meta, cs_sync, cs_prev;
    logic copi_meta, copi_sync;

    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic load, shift_enable;

    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;
    logic [7:0] hold;
    logic       hold_full;

    // Presets match the bus idle levels so reset release never fakes an edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_prev <= 1'b0;
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            cs_prev   <= 1'b1;
            copi_meta <= 1'b0;
            copi_sync <= 1'b0;
        end else begin
            sclk_meta <= i_spi_clk;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            cs_meta   <= i_spi_cs_n;
            cs_sync   <= cs_meta;
            cs_prev   <= cs_sync;
            copi_meta <= i_spi_copi;
            copi_sync <= copi_meta;
        end
    end

    assign sclk_rise = sclk_sync & ~sclk_prev;
    assign sclk_fall = ~sclk_sync & sclk_prev;
    assign cs_fall   = ~cs_sync & cs_prev;
    assign cs_rise   = cs_sync & ~cs_prev;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next   = state;
        load         = 1'b0;
        shift_enable = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next = ACTIVE;
                    load       = 1'b1;
                end
            end
            ACTIVE: begin
                // A deselect wins over any SCLK edge seen in the same cycle.
                if (cs_rise) begin
                    state_next = IDLE;
                end else begin
                    shift_enable = 1'b1;
                    load         = sclk_fall && (bit_cnt == 3'd0);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Receive path: bit counter, shift-in register and completed-byte strobe.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bit_cnt   <= 3'd0;
            rx_shift  <= 8'h00;
            o_rx_byte <= 8'h00;
            o_rx_dv   <= 1'b0;
        end else begin
            o_rx_dv <= 1'b0;
            if (state == IDLE && cs_fall) begin
                bit_cnt <= 3'd0;
            end else if (shift_enable && sclk_rise) begin
                rx_shift <= {rx_shift[6:0], copi_sync};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    o_rx_byte <= {rx_shift[6:0], copi_sync};
                    o_rx_dv   <= 1'b1;
                end
            end
        end
    end

    // Transmit path: shift-out register fed from the holding register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tx_shift <= 8'h00;
        end else if (load) begin
            tx_shift <= hold_full ? hold : IDLE_BYTE;
        end else if (shift_enable && sclk_fall) begin
            tx_shift <= {tx_shift[6:0], 1'b0};
        end
    end

    // A write landing on a load with an empty holder fills it for the next byte.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hold      <= 8'h00;
            hold_full <= 1'b0;
        end else if (load && hold_full) begin
            hold_full <= 1'b0;
        end else if (i_tx_dv && !hold_full) begin
            hold      <= i_tx_byte;
            hold_full <= 1'b1;
        end
    end

    assign o_tx_ready    = ~hold_full;
    assign o_spi_cipo    = tx_shift[7];
    assign o_spi_cipo_en = (state == ACTIVE);

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral acting as an SPI mode-0 controller with
// SCLK phases of four system clocks.
module tb_spi_peripheral;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_byte;
    logic       tx_dv;
    logic       tx_ready;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       sclk;
    logic       cs_n;
    logic       copi;
    logic       cipo;
    logic       cipo_en;

    int passed = 0;
    int total  = 0;
    int rx_pulses = 0;
    int base;
    logic [7:0] got;

    spi_peripheral #(.IDLE_BYTE(8'hFF)) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_tx_byte    (tx_byte),
        .i_tx_dv      (tx_dv),
        .o_tx_ready   (tx_ready),
        .o_rx_dv      (rx_dv),
        .o_rx_byte    (rx_byte),
        .i_spi_clk    (sclk),
        .i_spi_cs_n   (cs_n),
        .i_spi_copi   (copi),
        .o_spi_cipo   (cipo),
        .o_spi_cipo_en(cipo_en)
    );

    always #5 clk = ~clk;

    // Each cycle rx_dv is high counts once, so a single-byte delta of 1 also proves pulse width.
    always @(posedge clk) if (rx_dv) rx_pulses <= rx_pulses + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] b);
        tx_byte = b;
        tx_dv   = 1'b1;
        cycles(1);
        tx_dv   = 1'b0;
        cycles(1);
    endtask

    // Clocks nbits out MSB-first; the bit CIPO shows just before each rise lands in got.
    task automatic xfer(input logic [7:0] data, input int nbits, output logic [7:0] cap);
        cap = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            copi = data[7-i];
            cycles(4);
            cap[7-i] = cipo;
            sclk = 1'b1;
            cycles(4);
            sclk = 1'b0;
        end
        cycles(4);
    endtask

    task automatic select;
        cs_n = 1'b0;
        cycles(6);
    endtask

    task automatic deselect;
        cs_n = 1'b1;
        cycles(6);
    endtask

    initial begin
        rst_n = 1'b0; tx_byte = 8'h00; tx_dv = 1'b0;
        sclk = 1'b0; cs_n = 1'b1; copi = 1'b0;
        cycles(3);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_dv", rx_dv, 0);
        check("rst_rx_byte", rx_byte, 8'h00);
        check("rst_cipo", cipo, 0);
        check("rst_cipo_en", cipo_en, 0);
        rst_n = 1'b1;
        cycles(3);

        // Basic exchange with a loaded byte
        load_tx(8'hA5);
        check("load_ready_low", tx_ready, 0);
        base = rx_pulses;
        select;
        check("active_cipo_en", cipo_en, 1);
        check("ready_after_cs", tx_ready, 1);
        xfer(8'h3C, 8, got);
        check("a5_cipo", got, 8'hA5);
        check("a5_rx_byte", rx_byte, 8'h3C);
        check("a5_rx_pulses", rx_pulses - base, 1);
        deselect;
        check("idle_cipo_en", cipo_en, 0);

        // Nothing pending: IDLE_BYTE goes out
        base = rx_pulses;
        select;
        xfer(8'h5A, 8, got);
        check("idle_byte_cipo", got, 8'hFF);
        check("idle_byte_rx", rx_byte, 8'h5A);
        check("idle_byte_pulses", rx_pulses - base, 1);
        deselect;

        // Back-to-back bytes under one select
        load_tx(8'h12);
        base = rx_pulses;
        select;
        load_tx(8'h34);
        xfer(8'hA1, 8, got);
        check("b2b_first_cipo", got, 8'h12);
        check("b2b_first_rx", rx_byte, 8'hA1);
        xfer(8'hB2, 8, got);
        check("b2b_second_cipo", got, 8'h34);
        check("b2b_second_rx", rx_byte, 8'hB2);
        check("b2b_pulses", rx_pulses - base, 2);
        deselect;

        // Write while holder full is dropped
        load_tx(8'h66);
        load_tx(8'h77);
        select;
        xfer(8'h01, 8, got);
        check("ignored_cipo", got, 8'h66);
        xfer(8'h02, 8, got);
        check("ignored_next_cipo", got, 8'hFF);
        deselect;

        // Partial byte aborted by deselect
        base = rx_pulses;
        select;
        xfer(8'hF0, 5, got);
        deselect;
        check("partial_pulses", rx_pulses - base, 0);
        check("partial_rx_byte", rx_byte, 8'h02);
        load_tx(8'hC3);
        select;
        xfer(8'h0F, 8, got);
        check("restart_cipo", got, 8'hC3);
        check("restart_rx", rx_byte, 8'h0F);
        check("restart_pulses", rx_pulses - base, 1);
        deselect;

        // Reset mid-transfer
        load_tx(8'h99);
        select;
        xfer(8'hAA, 3, got);
        rst_n = 1'b0;
        cycles(2);
        check("midrst_tx_ready", tx_ready, 1);
        check("midrst_rx_dv", rx_dv, 0);
        check("midrst_rx_byte", rx_byte, 8'h00);
        check("midrst_cipo", cipo, 0);
        check("midrst_cipo_en", cipo_en, 0);
        cs_n = 1'b1;
        cycles(2);
        rst_n = 1'b1;
        cycles(4);
        load_tx(8'h5E);
        base = rx_pulses;
        select;
        xfer(8'h81, 8, got);
        check("postrst_cipo", got, 8'h5E);
        check("postrst_rx", rx_byte, 8'h81);
        check("postrst_pulses", rx_pulses - base, 1);
        deselect;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/spi_peripheral.md
SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 Parameter IDLE_BYTE, default 8'h00, byte shifted out on CIPO when no TX byte is pending at byte start.
REQ-002 i_clk  input  1  system clock; all logic on its rising edge.
REQ-003 i_reset_n  input  1  asynchronous, active-low reset.
REQ-004 i_tx_byte  input  8  next byte to return to the controller.
REQ-005 i_tx_dv  input  1  one-cycle valid pulse qualifying i_tx_byte.
REQ-006 o_tx_ready  output  1  high when the TX holding register is empty.
REQ-007 o_rx_dv  output  1  one-cycle pulse; o_rx_byte valid.
REQ-008 o_rx_byte  output  8  last complete byte received on COPI.
REQ-009 i_spi_clk  input  1  SPI clock from controller, asynchronous to i_clk.
REQ-010 i_spi_cs_n  input  1  active-low chip select, asynchronous.
REQ-011 i_spi_copi  input  1  controller-out/peripheral-in data, asynchronous.
REQ-012 o_spi_cipo  output  1  peripheral-out data.
REQ-013 o_spi_cipo_en  output  1  output enable for external CIPO tristate.

Function
REQ-014 The block SHALL support SPI mode 0 only (CPOL=0, CPHA=0), MSB first, 8-bit bytes.
REQ-015 i_spi_clk, i_spi_cs_n, and i_spi_copi SHALL each pass through a 2-flop synchronizer; edges SHALL be detected by comparing the synchronized value with its 1-cycle-delayed copy.
REQ-016 Operating limit: each i_spi_clk high/low phase >= 2 i_clk periods (SPI clock <= i_clk/4); behaviour beyond this is undefined.
REQ-017 States: IDLE (CS_n synced high) and ACTIVE (CS_n synced low); CS falling edge: IDLE->ACTIVE; CS rising edge: ACTIVE->IDLE from any bit position.
REQ-018 On IDLE->ACTIVE, the shift-out register SHALL load the holding register if full (emptying it), else IDLE_BYTE; the 3-bit bit counter SHALL clear to 0.
REQ-019 In ACTIVE, on each synced SCLK rising edge, synced COPI SHALL shift into the receive register LSB and the bit counter SHALL increment, wrapping 7->0.
REQ-020 On the rising edge taking the counter 7->0, o_rx_byte SHALL update with the full byte and o_rx_dv SHALL pulse high for exactly one cycle, in the cycle after that edge is detected.
REQ-021 In ACTIVE, on each synced SCLK falling edge, the shift-out register SHALL shift left by one; on the falling edge where the counter is 0 (after the 8th rise), it SHALL instead load the next byte per REQ-018 rules.
REQ-022 o_spi_cipo SHALL equal the shift-out register MSB; o_spi_cipo_en SHALL be high exactly in ACTIVE.
REQ-023 i_tx_dv with o_tx_ready high SHALL write the holding register, and o_tx_ready SHALL fall the next cycle; i_tx_dv with o_tx_ready low SHALL be ignored.
REQ-024 o_tx_ready SHALL rise the cycle after the holding register is consumed by a byte load.
REQ-025 If i_tx_dv coincides with a byte load while the holding register is empty, the load SHALL take IDLE_BYTE and i_tx_byte SHALL fill the holding register for the following byte.
REQ-026 A CS rising edge mid-byte (counter != 0) SHALL discard the partial byte with no o_rx_dv and leave the holding register unchanged.
REQ-027 SCLK edges while IDLE SHALL be ignored.

Reset
REQ-028 While i_reset_n is low: o_tx_ready=1, o_rx_dv=0, o_rx_byte=8'h00, o_spi_cipo=0, o_spi_cipo_en=0, state IDLE, counter 0, holding register empty, synchronizers preset to SCLK=0, CS_n=1, COPI=0.
REQ-029 Reset assertion mid-transfer SHALL abort immediately; after release, the block SHALL wait for a fresh CS falling edge.

Verification
REQ-030 Load 8'hA5, CS low, 8 SCLK pulses with COPI=8'h3C -> CIPO bits 1,0,1,0,0,1,0,1 sampled on rising edges; o_rx_dv one pulse, o_rx_byte=8'h3C; o_tx_ready high after CS fall.
REQ-031 No TX load, IDLE_BYTE=8'hFF, 8-bit transfer -> CIPO all 1s; rx byte received normally.
REQ-032 Two back-to-back bytes under one CS with 8'h12 then 8'h34 loaded during byte 1 -> CIPO 8'h12 then 8'h34; two o_rx_dv pulses.
REQ-033 CS rises after 5 SCLK pulses -> no o_rx_dv, o_rx_byte unchanged; next CS low restarts at bit 7.
REQ-034 i_tx_dv with 8'h77 while o_tx_ready=0 -> ignored; pending byte shifts out unchanged.
REQ-035 i_reset_n pulsed low after 3 bits -> all outputs at REQ-028 values; subsequent full transfer correct.
